// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C master arbiter.
package i2c_arb_pkg;
  // IDLE: wait for request | BUSY: master transfer | DONE: response pulse | GAP: STOP settle
  typedef enum logic [1:0] {IDLE, BUSY, DONE, GAP} arb_state_e;

  localparam int GAP_CYCLES = 2;

  localparam int DEV_MSB = 7;
  localparam int DEV_LSB = 6;
  localparam int MEM_MSB = 5;
  localparam int MEM_LSB = 0;
endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: first valid requester after last_grant wins.
module i2c_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IW-1:0]   last_grant,
  output logic [IW-1:0]   winner,
  output logic            any_valid
);

  int idx;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(last_grant) + 1 + i) % NREQ;
      if (!any_valid && req_valid[idx]) begin
        winner    = IW'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_apb_arbiter.sv
// Round-robin arbiter sharing one I2C master among NREQ requesters,
// with a bounded wait for m_ready and a settle gap after each transfer.
module i2c_apb_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_write,
  input  logic [8*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   resp_valid,
  output logic [7:0]        resp_rdata,
  output logic              resp_error,
  output logic              busy,
  output logic              m_ce,
  output logic              m_rden,
  output logic              m_wren,
  output logic [7:0]        m_addr,
  output logic [7:0]        m_wdata,
  input  logic [7:0]        m_rdata,
  input  logic              m_ready,
  input  logic              m_error
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  arb_state_e        state_q;
  logic [IW-1:0]     last_q;
  logic [CW-1:0]     cnt_q;
  logic [NREQ-1:0]   req_ack_q, resp_valid_q;
  logic [7:0]        resp_rdata_q, m_addr_q, m_wdata_q;
  logic              resp_error_q, m_ce_q, m_rden_q, m_wren_q;
  logic [IW-1:0]     pick_d;
  logic              any_d;
  logic [7:0]        addr_d;

  i2c_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_valid  (req_valid),
    .last_grant (last_q),
    .winner     (pick_d),
    .any_valid  (any_d)
  );

  assign addr_d = req_addr[8*int'(pick_d) +: 8];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= IW'(NREQ-1);
      cnt_q        <= '0;
      req_ack_q    <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      m_ce_q       <= 1'b0;
      m_rden_q     <= 1'b0;
      m_wren_q     <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
    end else begin
      req_ack_q    <= '0;
      resp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (any_d) begin
            state_q   <= BUSY;
            last_q    <= pick_d;
            cnt_q     <= '0;
            req_ack_q <= NREQ'(1) << pick_d;
            m_ce_q    <= 1'b1;
            m_wren_q  <= req_write[pick_d];
            m_rden_q  <= !req_write[pick_d];
            m_addr_q  <= {addr_d[DEV_MSB:DEV_LSB], addr_d[MEM_MSB:MEM_LSB]};
            m_wdata_q <= req_wdata[8*int'(pick_d) +: 8];
          end
        end
        BUSY: begin
          // m_ready is checked first so a same-cycle completion beats the timeout
          if (m_ready || cnt_q == CW'(TIMEOUT-1)) begin
            state_q      <= DONE;
            resp_valid_q <= NREQ'(1) << last_q;
            resp_rdata_q <= m_ready ? m_rdata : 8'h00;
            resp_error_q <= m_ready ? m_error : 1'b1;
            m_ce_q       <= 1'b0;
            m_rden_q     <= 1'b0;
            m_wren_q     <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= GAP;
          cnt_q   <= '0;
        end
        GAP: begin
          if (cnt_q == CW'(GAP_CYCLES-1)) state_q <= IDLE;
          else                            cnt_q   <= cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ack    = req_ack_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;
  assign busy       = (state_q != IDLE);
  assign m_ce       = m_ce_q;
  assign m_rden     = m_rden_q;
  assign m_wren     = m_wren_q;
  assign m_addr     = m_addr_q;
  assign m_wdata    = m_wdata_q;

endmodule

// File: tb/tb_i2c_apb_arbiter.sv
// Directed bench for i2c_apb_arbiter: a default-timeout instance plus a
// TIMEOUT=16 instance driven by the same stimulus.
module tb_i2c_apb_arbiter;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid, req_write;
  logic [8*NREQ-1:0] req_addr, req_wdata;
  logic [7:0]        m_rdata;
  logic              m_ready, m_error;

  logic [NREQ-1:0] req_ack, resp_valid, t_req_ack, t_resp_valid;
  logic [7:0]      resp_rdata, m_addr, m_wdata, t_resp_rdata, t_m_addr, t_m_wdata;
  logic            resp_error, busy, m_ce, m_rden, m_wren;
  logic            t_resp_error, t_busy, t_m_ce, t_m_rden, t_m_wren;

  int checks = 0;
  int failures = 0;

  i2c_apb_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .busy(busy), .m_ce(m_ce), .m_rden(m_rden), .m_wren(m_wren), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready), .m_error(m_error)
  );

  i2c_apb_arbiter #(.NREQ(NREQ), .TIMEOUT(16)) dut_to (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(t_req_ack),
    .resp_valid(t_resp_valid), .resp_rdata(t_resp_rdata), .resp_error(t_resp_error),
    .busy(t_busy), .m_ce(t_m_ce), .m_rden(t_m_rden), .m_wren(t_m_wren), .m_addr(t_m_addr),
    .m_wdata(t_m_wdata), .m_rdata(m_rdata), .m_ready(m_ready), .m_error(m_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         req;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         dly;
    logic [7:0] rdata;
    logic       merr;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || t_busy) && n < 200) begin step(); n++; end
    chk("idle_wait", {busy, t_busy}, 2'b00);
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin step(); n++; end while (req_ack == '0 && n < 20);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    logic ok;
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[v.req] = 1'b1;
    wait_idle();
    req_addr  = 32'hA5C3_9E17;
    req_wdata = 32'h6B2D_F048;
    req_write = 4'b1010;
    req_addr[8*v.req +: 8]  = v.addr;
    req_wdata[8*v.req +: 8] = v.wdata;
    req_write[v.req] = v.wr;
    req_valid = oh;
    wait_ack(n);
    req_valid = '0;
    chk("ack_latency", n, 1);
    chk("ack", req_ack, oh);
    chk("m_ce", m_ce, 1);
    chk("dir", {m_rden, m_wren}, {~v.wr, v.wr});
    chk("m_addr", m_addr, v.addr);
    chk("m_wdata", m_wdata, v.wdata);
    ok = 1'b1;
    for (int i = 0; i < v.dly; i++) begin
      step();
      if (!(m_ce && m_addr == v.addr && m_wdata == v.wdata && m_wren == v.wr &&
            m_rden == !v.wr && req_ack == '0 && resp_valid == '0)) ok = 1'b0;
    end
    chk("busy_hold", ok, 1);
    m_ready = 1'b1; m_rdata = v.rdata; m_error = v.merr;
    step();
    m_ready = 1'b0; m_rdata = 8'h00; m_error = 1'b0;
    chk("resp_valid", resp_valid, oh);
    chk("resp_rdata", resp_rdata, v.exp_rdata);
    chk("resp_error", resp_error, v.exp_err);
    chk("m_drop", {m_ce, m_rden, m_wren}, 3'b000);
    if (v.dly <= 15) begin
      chk("to_resp_valid", t_resp_valid, oh);
      chk("to_resp_rdata", t_resp_rdata, v.exp_rdata);
      chk("to_resp_error", t_resp_error, v.exp_err);
    end
    step();
    chk("gap1", {busy, m_ce, resp_valid}, {1'b1, 1'b0, 4'b0000});
    chk("rdata_hold", {resp_rdata, resp_error}, {v.exp_rdata, v.exp_err});
    step();
    chk("gap2", {busy, m_ce, resp_valid}, {1'b1, 1'b0, 4'b0000});
    step();
    chk("back_idle", busy, 0);
  endtask

  initial begin
    int n;
    logic ok;
    int ord[5];
    ord = '{0, 1, 2, 3, 0};

    //            req wr    addr   wdata  dly rdata  merr  exp_rd exp_err
    vecs[0] = '{0, 1'b0, 8'h41, 8'h00, 30, 8'h01, 1'b0, 8'h01, 1'b0};
    vecs[1] = '{2, 1'b1, 8'h41, 8'h5F, 5,  8'h3C, 1'b0, 8'h3C, 1'b0};
    vecs[2] = '{1, 1'b0, 8'hC5, 8'h12, 3,  8'h7E, 1'b1, 8'h7E, 1'b1};
    vecs[3] = '{3, 1'b1, 8'h82, 8'hA5, 0,  8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{1, 1'b0, 8'h3F, 8'h00, 14, 8'hFF, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{0, 1'b0, 8'h10, 8'h00, 15, 8'h99, 1'b0, 8'h99, 1'b0};

    reset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    m_rdata = '0; m_ready = 1'b0; m_error = 1'b0;
    repeat (3) step();
    chk("reset_outputs",
        {req_ack, resp_valid, resp_rdata, resp_error, busy, m_ce, m_rden, m_wren, m_addr, m_wdata},
        64'd0);
    reset = 1'b0;

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // timeout on the TIMEOUT=16 instance; m_ready withheld
    wait_idle();
    req_addr = 32'h0000_6600; req_write = 4'b0000; req_valid = 4'b0010;
    wait_ack(n);
    req_valid = '0;
    chk("to_ack", t_req_ack, 4'b0010);
    n = 0;
    while (t_resp_valid == '0 && n < 40) begin step(); n++; end
    chk("to_cycles", n, 16);
    chk("to_resp_valid", t_resp_valid, 4'b0010);
    chk("to_resp_error", t_resp_error, 1);
    chk("to_resp_rdata", t_resp_rdata, 8'h00);
    chk("to_m_ce", t_m_ce, 0);
    chk("main_still_busy", {m_ce, resp_valid}, {1'b1, 4'b0000});
    m_ready = 1'b1; m_rdata = 8'h5A;
    step();
    m_ready = 1'b0;
    chk("main_release", {resp_valid, resp_rdata, resp_error}, {4'b0010, 8'h5A, 1'b0});

    // reset during BUSY, then full contention from reset
    wait_idle();
    req_addr = 32'h0000_0000; req_write = 4'b0100; req_wdata = 32'h0077_0000; req_valid = 4'b0100;
    wait_ack(n);
    req_valid = '0;
    chk("pre_reset_ack", req_ack, 4'b0100);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_drop", {m_ce, busy, req_ack}, 6'b0);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    ok = (resp_valid == '0);
    repeat (6) begin step(); if (resp_valid != '0 || t_resp_valid != '0) ok = 1'b0; end
    chk("no_resp_after_reset", ok, 1);

    req_addr = 32'h3322_1100; req_write = 4'b0000; req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(n);
      chk("rr_grant", req_ack, 4'b0001 << ord[k]);
      chk("rr_addr", m_addr, 8'h11 * ord[k]);
      step(); step();
      m_ready = 1'b1; m_rdata = 8'(k);
      step();
      m_ready = 1'b0;
      chk("rr_resp", {resp_valid, resp_rdata}, {4'b0001 << ord[k], 8'(k)});
    end
    req_valid = '0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
